// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state type, core-owner type and memory-state codes
// shared by mem_arbiter and its bench.
// Memory-state codes mirror riscv_defs.v. They are guarded so that an earlier
// inclusion of that file takes precedence.
`ifndef MEM_IDLE
`define MEM_IDLE 3'b000
`endif
`ifndef FETCH_DECODE
`define FETCH_DECODE 3'b001
`endif
`ifndef LOAD_STORE
`define LOAD_STORE 3'b010
`endif

package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT_IF = 2'd1,
      ST_GRANT_LS = 2'd2,
      ST_GRANT_LD = 2'd3
   } arb_state_e;

   typedef enum logic {
      CORE_IF = 1'b0,
      CORE_LS = 1'b1
   } core_e;

   localparam logic [2:0] MEM_STATE_IDLE  = `MEM_IDLE;
   localparam logic [2:0] MEM_STATE_FETCH = `FETCH_DECODE;
   localparam logic [2:0] MEM_STATE_LS    = `LOAD_STORE;

   // On a fetch/load-store tie, the core that was not served last wins.
   function automatic arb_state_e tie_winner(input core_e last_core);
      return (last_core == CORE_IF) ? ST_GRANT_LS : ST_GRANT_IF;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one dual-port memory between instruction fetch (port A),
// load/store (port B) and an optional loader (port B, full-word writes).
// Each access takes an arbitration cycle and a grant cycle.
// Optional feature macro: MEM_ARB_LOADER_EN enables the ld_* port and GRANT_LD.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | arbitrate among requesters; any rvalid of the last access
// ST_GRANT_IF | fetch owns port A for one cycle
// ST_GRANT_LS | load/store owns port B for one cycle
// ST_GRANT_LD | loader writes a full word on port B for one cycle
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int NUM_COL    = 4,
   parameter int COL_WIDTH  = 8,
   localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,

   input  logic                  ls_req_i,
   input  logic [NUM_COL-1:0]    ls_we_i,
   input  logic [ADDR_WIDTH-1:0] ls_addr_i,
   input  logic [DATA_WIDTH-1:0] ls_wdata_i,
   output logic                  ls_gnt_o,
   output logic                  ls_rvalid_o,
   output logic [DATA_WIDTH-1:0] ls_rdata_o,

`ifdef MEM_ARB_LOADER_EN
   input  logic                  ld_req_i,
   input  logic [ADDR_WIDTH-1:0] ld_addr_i,
   input  logic [DATA_WIDTH-1:0] ld_wdata_i,
   output logic                  ld_gnt_o,
`endif
   output logic                  core_stall_o,

   output logic [2:0]            mem_state_o,
   output logic                  mem_ena_a_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_a_o,
   input  logic [DATA_WIDTH-1:0] mem_dout_a_i,
   output logic                  mem_ena_b_o,
   output logic [NUM_COL-1:0]    mem_we_b_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_b_o,
   output logic [DATA_WIDTH-1:0] mem_din_b_o,
   input  logic [DATA_WIDTH-1:0] mem_dout_b_i
);

   arb_state_e state_q;
   arb_state_e state_d;
   core_e      last_core_q;
   logic       if_rvalid_q;
   logic       ls_rvalid_q;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Read-valid flags trail the grant by one cycle; fairness tracks core grants only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_core_q <= CORE_IF;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
      end else begin
         if_rvalid_q <= (state_q == ST_GRANT_IF);
         ls_rvalid_q <= (state_q == ST_GRANT_LS) && (ls_we_i == '0);
         if (state_q == ST_GRANT_IF) begin
            last_core_q <= CORE_IF;
         end else if (state_q == ST_GRANT_LS) begin
            last_core_q <= CORE_LS;
         end
      end
   end

   // Next-state arbitration and memory/grant outputs decoded from the current state.
   always_comb begin
      state_d      = ST_IDLE;
      mem_state_o  = MEM_STATE_IDLE;
      mem_ena_a_o  = 1'b0;
      mem_addr_a_o = '0;
      mem_ena_b_o  = 1'b0;
      mem_we_b_o   = '0;
      mem_addr_b_o = '0;
      mem_din_b_o  = '0;
      if_gnt_o     = 1'b0;
      ls_gnt_o     = 1'b0;
`ifdef MEM_ARB_LOADER_EN
      ld_gnt_o     = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
`ifdef MEM_ARB_LOADER_EN
            if (ld_req_i) begin
               state_d = ST_GRANT_LD;
            end else
`endif
            if (if_req_i && ls_req_i) begin
               state_d = tie_winner(last_core_q);
            end else if (if_req_i) begin
               state_d = ST_GRANT_IF;
            end else if (ls_req_i) begin
               state_d = ST_GRANT_LS;
            end
         end
         ST_GRANT_IF: begin
            mem_state_o  = MEM_STATE_FETCH;
            mem_ena_a_o  = 1'b1;
            mem_addr_a_o = if_addr_i;
            if_gnt_o     = 1'b1;
         end
         ST_GRANT_LS: begin
            mem_state_o  = MEM_STATE_LS;
            mem_ena_b_o  = 1'b1;
            mem_we_b_o   = ls_we_i;
            mem_addr_b_o = ls_addr_i;
            mem_din_b_o  = ls_wdata_i;
            ls_gnt_o     = 1'b1;
         end
`ifdef MEM_ARB_LOADER_EN
         ST_GRANT_LD: begin
            mem_state_o  = MEM_STATE_LS;
            mem_ena_b_o  = 1'b1;
            mem_we_b_o   = '1;
            mem_addr_b_o = ld_addr_i;
            mem_din_b_o  = ld_wdata_i;
            ld_gnt_o     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

`ifdef MEM_ARB_LOADER_EN
   assign core_stall_o = ld_req_i || (state_q == ST_GRANT_LD);
`else
   assign core_stall_o = 1'b0;
`endif

   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign if_rdata_o  = mem_dout_a_i;
   assign ls_rdata_o  = mem_dout_b_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a slot-level model of the arbiter
// and a reference copy of the memory contents.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW    = 14;
   localparam int NC    = 4;
   localparam int CW    = 8;
   localparam int DW    = NC * CW;
   localparam int WORDS = 1 << AW;

   localparam int W_NONE = 0;
   localparam int W_IF   = 1;
   localparam int W_LS   = 2;
   localparam int W_LD   = 3;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          if_req_i = 1'b0;
   logic [AW-1:0] if_addr_i = '0;
   logic          if_gnt_o, if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          ls_req_i = 1'b0;
   logic [NC-1:0] ls_we_i = '0;
   logic [AW-1:0] ls_addr_i = '0;
   logic [DW-1:0] ls_wdata_i = '0;
   logic          ls_gnt_o, ls_rvalid_o;
   logic [DW-1:0] ls_rdata_o;
   logic          ld_req_i = 1'b0;
   logic [AW-1:0] ld_addr_i = '0;
   logic [DW-1:0] ld_wdata_i = '0;
`ifdef MEM_ARB_LOADER_EN
   logic          ld_gnt_o;
`endif
   logic          core_stall_o;
   logic [2:0]    mem_state_o;
   logic          mem_ena_a_o, mem_ena_b_o;
   logic [AW-1:0] mem_addr_a_o, mem_addr_b_o;
   logic [NC-1:0] mem_we_b_o;
   logic [DW-1:0] mem_din_b_o;
   logic [DW-1:0] mem_dout_a_i, mem_dout_b_i;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.ADDR_WIDTH(AW), .NUM_COL(NC), .COL_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
      .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
      .ls_rdata_o(ls_rdata_o),
`ifdef MEM_ARB_LOADER_EN
      .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
      .ld_gnt_o(ld_gnt_o),
`endif
      .core_stall_o(core_stall_o),
      .mem_state_o(mem_state_o), .mem_ena_a_o(mem_ena_a_o), .mem_addr_a_o(mem_addr_a_o),
      .mem_dout_a_i(mem_dout_a_i), .mem_ena_b_o(mem_ena_b_o), .mem_we_b_o(mem_we_b_o),
      .mem_addr_b_o(mem_addr_b_o), .mem_din_b_o(mem_din_b_o), .mem_dout_b_i(mem_dout_b_i)
   );

   // Power-on memory contents, with the two words the directed scenarios rely on.
   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 14'h010) return 32'h0000_0013;
      if (a == 14'h020) return 32'h1122_3344;
      return 32'(a) * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   // Simulated dual-port RAM driven by the DUT's memory-side ports.
   logic [DW-1:0] ram [0:WORDS-1];
   bit            ram_wr [0:WORDS-1];

   function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
      return ram_wr[a] ? ram[a] : init_word(a);
   endfunction

   always @(posedge clk_i) begin
      logic [DW-1:0] w;
      if (mem_ena_a_o === 1'b1) mem_dout_a_i <= ram_rd(mem_addr_a_o);
      if (mem_ena_b_o === 1'b1) begin
         mem_dout_b_i <= ram_rd(mem_addr_b_o);
         if (mem_we_b_o != '0) begin
            w = ram_rd(mem_addr_b_o);
            for (int i = 0; i < NC; i++)
               if (mem_we_b_o[i]) w[i*CW +: CW] = mem_din_b_o[i*CW +: CW];
            ram[mem_addr_b_o]    <= w;
            ram_wr[mem_addr_b_o] <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the memory this cycle, expected read returns,
   // and the memory contents as the requesters intended them.
   logic [DW-1:0] ref_mem [0:WORDS-1];
   bit            ref_ready = 1'b0;
   bit            armed = 1'b0;
   int            m_who = W_NONE;
   int            m_prev_who = W_NONE;
   int            m_last = W_IF;
   bit            m_rv_if = 1'b0, m_rv_ls = 1'b0;
   logic [DW-1:0] m_rd_if = '0, m_rd_ls = '0;

   always @(negedge clk_i) begin
      int            n_who, n_last;
      bit            n_rv_if, n_rv_ls;
      logic [DW-1:0] n_rd_if, n_rd_ls;
      logic [2:0]    e_state;
      if (!ref_ready) begin
         for (int a = 0; a < WORDS; a++) ref_mem[a] = init_word(AW'(a));
         ref_ready = 1'b1;
      end
      if (armed) begin
         e_state = (m_who == W_IF) ? MEM_STATE_FETCH :
                   (m_who == W_LS || m_who == W_LD) ? MEM_STATE_LS : MEM_STATE_IDLE;
         chk("mdl_state", mem_state_o, e_state);
         chk("mdl_if_gnt", if_gnt_o, m_who == W_IF);
         chk("mdl_ls_gnt", ls_gnt_o, m_who == W_LS);
         chk("mdl_ena_a", mem_ena_a_o, m_who == W_IF);
         chk("mdl_ena_b", mem_ena_b_o, m_who == W_LS || m_who == W_LD);
         chk("mdl_we_b", mem_we_b_o, (m_who == W_LS) ? ls_we_i : (m_who == W_LD) ? 4'hF : 4'h0);
         if (m_who == W_IF) chk("mdl_addr_a", mem_addr_a_o, if_addr_i);
         if (m_who == W_LS) begin
            chk("mdl_addr_b", mem_addr_b_o, ls_addr_i);
            chk("mdl_din_b", mem_din_b_o, ls_wdata_i);
         end
         if (m_who == W_LD) begin
            chk("mdl_ld_addr_b", mem_addr_b_o, ld_addr_i);
            chk("mdl_ld_din_b", mem_din_b_o, ld_wdata_i);
         end
`ifdef MEM_ARB_LOADER_EN
         chk("mdl_ld_gnt", ld_gnt_o, m_who == W_LD);
         chk("mdl_stall", core_stall_o, ld_req_i || m_who == W_LD);
`else
         chk("mdl_stall", core_stall_o, 1'b0);
`endif
         chk("mdl_if_rvalid", if_rvalid_o, m_rv_if);
         chk("mdl_ls_rvalid", ls_rvalid_o, m_rv_ls);
         if (m_rv_if) chk("mdl_if_rdata", if_rdata_o, m_rd_if);
         if (m_rv_ls) chk("mdl_ls_rdata", ls_rdata_o, m_rd_ls);
      end
      // A grant cycle returns data next cycle; its write lands in memory regardless of reset.
      n_rv_if = (m_who == W_IF);
      n_rd_if = ref_mem[if_addr_i];
      n_rv_ls = (m_who == W_LS) && (ls_we_i == '0);
      n_rd_ls = ref_mem[ls_addr_i];
      if (m_who == W_LS)
         for (int i = 0; i < NC; i++)
            if (ls_we_i[i]) ref_mem[ls_addr_i][i*CW +: CW] = ls_wdata_i[i*CW +: CW];
      if (m_who == W_LD) ref_mem[ld_addr_i] = ld_wdata_i;
      n_last = (m_who == W_IF) ? W_IF : (m_who == W_LS) ? W_LS : m_last;
      if (m_who != W_NONE)        n_who = W_NONE;
      else if (ld_req_i)          n_who = W_LD;
      else if (if_req_i && ls_req_i) n_who = (m_last == W_IF) ? W_LS : W_IF;
      else if (if_req_i)          n_who = W_IF;
      else if (ls_req_i)          n_who = W_LS;
      else                        n_who = W_NONE;
      if (rst_i) begin
         n_who = W_NONE; n_rv_if = 1'b0; n_rv_ls = 1'b0; n_last = W_IF;
         armed = 1'b1;
      end
      m_prev_who = m_who;
      m_who = n_who; m_last = n_last;
      m_rv_if = n_rv_if; m_rv_ls = n_rv_ls;
      m_rd_if = n_rd_if; m_rd_ls = n_rd_ls;
   end

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; if_req_i = 1'b0; ls_req_i = 1'b0; ld_req_i = 1'b0; ls_we_i = '0;
      step(); step();
      rst_i = 1'b0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return AW'($urandom_range(0, 63));
   endfunction

   initial begin
      // Single fetch: grant in cycle 1, data in cycle 2.
      do_reset();
      if_req_i = 1'b1; if_addr_i = 14'h010;
      settle(); chk("r027_gnt_c0", if_gnt_o, 1'b0);
      step(); settle();
      chk("r027_gnt_c1", if_gnt_o, 1'b1);
      chk("r027_state_c1", mem_state_o, MEM_STATE_FETCH);
      step(); if_req_i = 1'b0; settle();
      chk("r027_rvalid_c2", if_rvalid_o, 1'b1);
      chk("r027_rdata_c2", if_rdata_o, 32'h0000_0013);
      step(); settle(); chk("r027_rvalid_c3", if_rvalid_o, 1'b0);

      // Both cores held: LS, IF, LS at cycles 1, 3, 5.
      do_reset();
      if_req_i = 1'b1; if_addr_i = 14'h011;
      ls_req_i = 1'b1; ls_we_i = 4'h0; ls_addr_i = 14'h030;
      for (int c = 0; c < 6; c++) begin
         settle();
         chk("r028_ls_gnt", ls_gnt_o, (c == 1) || (c == 5));
         chk("r028_if_gnt", if_gnt_o, c == 3);
         step();
      end
      if_req_i = 1'b0; ls_req_i = 1'b0;

      // Byte-lane write, then read back the merged word.
      do_reset();
      ls_req_i = 1'b1; ls_we_i = 4'b0010; ls_addr_i = 14'h020; ls_wdata_i = 32'h0000_AB00;
      step(); settle();
      chk("r029_gnt", ls_gnt_o, 1'b1);
      chk("r029_we", mem_we_b_o, 4'b0010);
      step(); ls_req_i = 1'b0; ls_we_i = 4'h0; settle();
      chk("r029_no_rvalid", ls_rvalid_o, 1'b0);
      step(); ls_req_i = 1'b1; ls_addr_i = 14'h020; settle();
      chk("r029_no_rvalid2", ls_rvalid_o, 1'b0);
      step(); settle(); chk("r029_rd_gnt", ls_gnt_o, 1'b1);
      step(); ls_req_i = 1'b0; settle();
      chk("r029_rd_rvalid", ls_rvalid_o, 1'b1);
      chk("r029_rd_data", ls_rdata_o, 32'h1122_AB44);
      step();

      // Reset during a load grant loses the access.
      do_reset();
      ls_req_i = 1'b1; ls_we_i = 4'h0; ls_addr_i = 14'h040;
      step(); rst_i = 1'b1; settle(); chk("r031_gnt", ls_gnt_o, 1'b1);
      step(); rst_i = 1'b0; ls_req_i = 1'b0; settle();
      chk("r031_rvalid", ls_rvalid_o, 1'b0);
      chk("r031_idle", mem_state_o, MEM_STATE_IDLE);
      step();

      // A fetch request raised during a load/store grant and dropped before arbitration is cancelled.
      do_reset();
      ls_req_i = 1'b1; ls_addr_i = 14'h041;
      step(); if_req_i = 1'b1; if_addr_i = 14'h012;
      step(); ls_req_i = 1'b0; if_req_i = 1'b0; settle();
      chk("cancel_gnt_c2", if_gnt_o, 1'b0);
      step(); settle();
      chk("cancel_gnt_c3", if_gnt_o, 1'b0);
      chk("cancel_ena_c3", mem_ena_a_o, 1'b0);
      step();

`ifdef MEM_ARB_LOADER_EN
      // Loader outranks fetch and stalls the core while requesting.
      do_reset();
      ld_req_i = 1'b1; ld_addr_i = 14'h050; ld_wdata_i = 32'hCAFE_F00D;
      if_req_i = 1'b1; if_addr_i = 14'h010;
      for (int c = 0; c < 6; c++) begin
         settle();
         chk("r030_ld_gnt", ld_gnt_o, (c == 1) || (c == 3) || (c == 5));
         chk("r030_if_gnt", if_gnt_o, 1'b0);
         chk("r030_stall", core_stall_o, 1'b1);
         step();
      end
      ld_req_i = 1'b0; settle();
      chk("r030_stall_off", core_stall_o, 1'b0);
      step(); settle(); chk("r030_if_after", if_gnt_o, 1'b1);
      step(); if_req_i = 1'b0; step();
`endif

      // Random traffic obeying the hold-until-grant protocol.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst_i = ($urandom_range(0, 299) == 0);
         if (m_who == W_IF) begin
         end else if (if_req_i && m_prev_who == W_IF) begin
            if_req_i = $urandom_range(0, 1) == 1; if_addr_i = rand_addr();
         end else if (if_req_i) begin
            if ($urandom_range(0, 15) == 0) if_req_i = 1'b0;
         end else begin
            if_req_i = $urandom_range(0, 2) == 0; if_addr_i = rand_addr();
         end
         if (m_who == W_LS) begin
         end else if (!ls_req_i || m_prev_who == W_LS) begin
            ls_req_i   = (ls_req_i && m_prev_who == W_LS) ? ($urandom_range(0, 1) == 1)
                                                          : ($urandom_range(0, 2) == 0);
            ls_addr_i  = rand_addr();
            ls_we_i    = ($urandom_range(0, 1) == 1) ? 4'h0 : NC'($urandom_range(1, 15));
            ls_wdata_i = $urandom;
         end else if ($urandom_range(0, 15) == 0) begin
            ls_req_i = 1'b0;
         end
`ifdef MEM_ARB_LOADER_EN
         if (m_who == W_LD) begin
         end else if (ld_req_i && m_prev_who == W_LD) begin
            ld_req_i = $urandom_range(0, 3) == 0; ld_addr_i = rand_addr(); ld_wdata_i = $urandom;
         end else if (!ld_req_i) begin
            ld_req_i = $urandom_range(0, 11) == 0; ld_addr_i = rand_addr(); ld_wdata_i = $urandom;
         end
`endif
         step();
      end
      rst_i = 1'b0; if_req_i = 1'b0; ls_req_i = 1'b0; ld_req_i = 1'b0;
      step(); step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning word-address width of the shared memory.
REQ-002 SHALL have parameter NUM_COL, default 4, meaning byte lanes per word.
REQ-003 SHALL have parameter COL_WIDTH, default 8, meaning bits per lane; DATA_WIDTH = NUM_COL*COL_WIDTH.
REQ-004 SHALL have ports (name direction width meaning): clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports if_req_i in 1 fetch request; if_addr_i in ADDR_WIDTH fetch word address; if_gnt_o out 1 fetch granted; if_rvalid_o out 1 fetch data valid; if_rdata_o out DATA_WIDTH fetch data.
REQ-006 SHALL have ports ls_req_i in 1; ls_we_i in NUM_COL byte write enables; ls_addr_i in ADDR_WIDTH; ls_wdata_i in DATA_WIDTH; ls_gnt_o out 1; ls_rvalid_o out 1; ls_rdata_o out DATA_WIDTH.
REQ-007 SHALL have ports ld_req_i in 1 loader write request; ld_addr_i in ADDR_WIDTH; ld_wdata_i in DATA_WIDTH; ld_gnt_o out 1; core_stall_o out 1 loader owns memory.
REQ-008 SHALL have memory-side ports mem_state_o out 3; mem_ena_a_o out 1; mem_addr_a_o out ADDR_WIDTH; mem_dout_a_i in DATA_WIDTH; mem_ena_b_o out 1; mem_we_b_o out NUM_COL; mem_addr_b_o out ADDR_WIDTH; mem_din_b_o out DATA_WIDTH; mem_dout_b_i in DATA_WIDTH.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT_IF, GRANT_LS, GRANT_LD; every non-IDLE state lasts exactly one cycle and returns to IDLE.
REQ-010 SHALL, in IDLE, select at most one requester: ld_req_i first; else if only one of if_req_i/ls_req_i, that one; else if both, the one not granted last (last_core_q), initial winner LS.
REQ-011 SHALL, in GRANT_IF, drive mem_ena_a_o=1, mem_addr_a_o=if_addr_i, mem_state_o=`FETCH_DECODE, if_gnt_o=1.
REQ-012 SHALL, in GRANT_LS, drive mem_ena_b_o=1, mem_addr_b_o=ls_addr_i, mem_we_b_o=ls_we_i, mem_din_b_o=ls_wdata_i, mem_state_o=`LOAD_STORE, ls_gnt_o=1.
REQ-013 SHALL, in GRANT_LD, drive port B as REQ-012 with ld_addr_i, ld_wdata_i, mem_we_b_o all ones, ld_gnt_o=1.
REQ-014 SHALL, in IDLE, drive mem_state_o=`MEM_IDLE, all enables, write enables and gnt outputs 0.
REQ-015 SHALL assert if_rvalid_o exactly one cycle after GRANT_IF, and ls_rvalid_o one cycle after GRANT_LS only if ls_we_i was zero at grant; rdata_o passes mem_dout_a_i/mem_dout_b_i in that cycle.
REQ-016 SHALL sustain one access per two cycles; rvalid of access N coincides with IDLE arbitration for access N+1.
REQ-017 Requesters SHALL hold req and payload stable until gnt; payload sampled only in the grant cycle; req dropped before grant is legal and cancels.
REQ-018 SHALL assert core_stall_o whenever ld_req_i=1 or state is GRANT_LD.
REQ-019 SHALL update last_core_q only on GRANT_IF/GRANT_LS; loader grants do not change it.

Reset
REQ-020 SHALL, on rst_i=1 at a clock edge, enter IDLE, clear all gnt, rvalid, enables, core_stall_o; set last_core_q=IF (so LS wins first tie).
REQ-021 SHALL, with reset asserted in a GRANT cycle, suppress the following rvalid; the access is lost and must be re-requested.
REQ-022 rdata outputs are don't-care when the matching rvalid is 0.

Configuration
REQ-023 SHALL compile the loader port and GRANT_LD only when MEM_ARB_LOADER_EN is defined.
REQ-024 SHALL, without MEM_ARB_LOADER_EN, omit ld_* ports, tie core_stall_o to 0, arbitrate IF/LS only.

Structure
REQ-025 SHALL take `FETCH_DECODE, `LOAD_STORE and new `MEM_IDLE (distinct 3-bit code) from riscv_defs.v; FSM encodings local.
REQ-026 SHALL be a single module; no sub-module.

Verification
REQ-027 if_req_i=1, addr 0x010, mem word 0x00000013 -> if_gnt_o cycle 1, if_rvalid_o=1 with 0x00000013 cycle 2.
REQ-028 if_req_i and ls_req_i held 6 cycles after reset -> grants LS, IF, LS alternating at cycles 1,3,5.
REQ-029 ls_we_i=4'b0010, addr 0x020, wdata 0x0000AB00 over word 0x11223344 -> word becomes 0x1122AB44, no ls_rvalid_o.
REQ-030 ld_req_i with if_req_i both held -> ld_gnt_o each grant slot, if_gnt_o never, core_stall_o=1 until ld_req_i drops.
REQ-031 rst_i pulsed in GRANT_LS read cycle -> ls_rvalid_o stays 0, FSM in IDLE next cycle.
REQ-032 Build without MEM_ARB_LOADER_EN -> REQ-027..029 pass, core_stall_o constant 0.
